// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the TCDM bank arbiter.
// Bus payload widths are sized for the largest supported configuration.
// Users narrow them with explicit width casts.
package tcdm_arb_pkg;

    localparam int unsigned MAX_REQ    = 32;
    localparam int unsigned MAX_IDX_W  = 5;
    localparam int unsigned MAX_ADDR_W = 32;
    localparam int unsigned MAX_DATA_W = 128;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    // One bank access as seen by the SRAM macro.
    typedef struct packed {
        logic                  we;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata;
        logic [MAX_BE_W-1:0]   be;
    } bank_req_t;

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : per-requester request
//   advance_i    : a grant was accepted this cycle; move pointer past the winner
//   gnt_c        : combinational one-hot grant (zero when no request)
//   idx_c        : combinational index of the granted requester
module tcdm_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NB_REQ = 4,
    localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NB_REQ-1:0] req_i,
    input  logic              advance_i,
    output logic [NB_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]  idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // First asserted request at or above the pointer, wrapping around.
    always_comb begin
        int unsigned cand;
        logic        found;
        gnt_c = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NB_REQ) begin
                cand = cand - NB_REQ;
            end
            if (!found && req_i[IDX_W'(cand)]) begin
                gnt_c[IDX_W'(cand)] = 1'b1;
                found               = 1'b1;
            end
        end
        idx_c = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_c)));
    end

    // Pointer moves to the requester after the winner, modulo NB_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_c == IDX_W'(NB_REQ - 1)) ? '0 : idx_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Shares one 1-cycle-latency TCDM SRAM bank between NB_REQ requesters.
// Round-robin grant in the request cycle; response (read data or write ack)
// returned to the granted requester on the following cycle. Optionally
// zero-fills the bank after reset before accepting traffic.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   req_i/wen_i/add_i/wdata_i/be_i    : requester side (wen_i active-low)
//   gnt_o, r_valid_o, r_rdata_o       : grant, response valid, shared response data
//   bank_*_o, bank_rdata_i            : SRAM bank side (bank_we_o active-high)
//   init_done_o                       : bank ready for traffic
module tcdm_bank_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NB_REQ        = 4,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          INIT_ON_RESET = 1'b1,
    localparam int unsigned BE_W  = DATA_WIDTH / 8,
    localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_REQ-1:0]                    req_i,
    input  logic [NB_REQ-1:0]                    wen_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    add_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NB_REQ-1:0][BE_W-1:0]          be_i,
    output logic [NB_REQ-1:0]                    gnt_o,
    output logic [NB_REQ-1:0]                    r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 bank_req_o,
    output logic                                 bank_we_o,
    output logic [ADDR_WIDTH-1:0]                bank_addr_o,
    output logic [DATA_WIDTH-1:0]                bank_wdata_o,
    output logic [BE_W-1:0]                      bank_be_o,
    input  logic [DATA_WIDTH-1:0]                bank_rdata_i,
    output logic                                 init_done_o
);

    arb_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    rvalid_q, rvalid_d;
    logic [IDX_W-1:0]        ridx_q, ridx_d;

    logic [NB_REQ-1:0]       arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    advance;
    bank_req_t               sel;

    tcdm_rr_arbiter #(
        .NB_REQ (NB_REQ)
    ) i_rr_arbiter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (advance),
        .gnt_c     (arb_gnt),
        .idx_c     (arb_idx)
    );

    // FSM next state, zero-fill sequencing and bank request mux.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        gnt_o       = '0;
        advance     = 1'b0;
        bank_req_o  = 1'b0;
        sel         = '0;

        case (state_q)
            INIT: begin
                bank_req_o = 1'b1;
                sel.we     = 1'b1;
                sel.addr   = MAX_ADDR_W'(cnt_q);
                sel.wdata  = '0;
                sel.be     = '1;
                cnt_d      = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d     = SERVE;
                    init_done_d = 1'b1;
                end
            end
            SERVE: begin
                if (|req_i) begin
                    gnt_o      = arb_gnt;
                    advance    = 1'b1;
                    bank_req_o = 1'b1;
                    sel.we     = ~wen_i[arb_idx];
                    sel.addr   = MAX_ADDR_W'(add_i[arb_idx]);
                    sel.wdata  = MAX_DATA_W'(wdata_i[arb_idx]);
                    sel.be     = MAX_BE_W'(be_i[arb_idx]);
                end
            end
            default: begin
                state_d = SERVE;
            end
        endcase

        // No access may leave the arbiter while reset is held.
        if (rst_i) begin
            gnt_o      = '0;
            advance    = 1'b0;
            bank_req_o = 1'b0;
        end
    end

    // Response tracking: remember who was granted so the next cycle can ack them.
    always_comb begin
        rvalid_d = advance;
        ridx_d   = advance ? arb_idx : ridx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT_ON_RESET ? INIT : SERVE;
            cnt_q       <= '0;
            init_done_q <= !INIT_ON_RESET;
            rvalid_q    <= 1'b0;
            ridx_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rvalid_q    <= rvalid_d;
            ridx_q      <= ridx_d;
        end
    end

    assign bank_we_o    = sel.we;
    assign bank_addr_o  = ADDR_WIDTH'(sel.addr);
    assign bank_wdata_o = DATA_WIDTH'(sel.wdata);
    assign bank_be_o    = BE_W'(sel.be);

    assign r_valid_o    = rvalid_q ? (NB_REQ'(1) << ridx_q) : '0;
    assign r_rdata_o    = bank_rdata_i;
    assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter with a behavioural 1-cycle SRAM bank.
module tb_tcdm_bank_arbiter;

    localparam int unsigned NB = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NB-1:0]            req;
    logic [NB-1:0]            wen;
    logic [NB-1:0][AW-1:0]    add;
    logic [NB-1:0][DW-1:0]    wdata;
    logic [NB-1:0][BW-1:0]    be;
    logic [NB-1:0]            gnt;
    logic [NB-1:0]            r_valid;
    logic [DW-1:0]            r_rdata;
    logic                     bank_req;
    logic                     bank_we;
    logic [AW-1:0]            bank_addr;
    logic [DW-1:0]            bank_wdata;
    logic [BW-1:0]            bank_be;
    logic [DW-1:0]            bank_rdata = '0;
    logic                     init_done;

    logic [DW-1:0]            mem [2**AW];
    logic                     mem_loaded = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tcdm_bank_arbiter #(
        .NB_REQ        (NB),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .wen_i        (wen),
        .add_i        (add),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt),
        .r_valid_o    (r_valid),
        .r_rdata_o    (r_rdata),
        .bank_req_o   (bank_req),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_be_o    (bank_be),
        .bank_rdata_i (bank_rdata),
        .init_done_o  (init_done)
    );

    // Behavioural SRAM bank; preloaded with a non-zero pattern so zero-fill is visible.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 32'hA5A5_A5A5;
            mem_loaded <= 1'b1;
        end else if (bank_req) begin
            if (bank_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (bank_be[b]) mem[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
                end
            end else begin
                bank_rdata <= mem[bank_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        req   = '0;
        wen   = '1;
        add   = '0;
        wdata = '0;
        be    = '1;
    endtask

    initial begin
        idle_inputs();
        req = '1;
        rst = 1'b1;

        // Reset state, grants gated while reset is high
        @(negedge clk); @(negedge clk); #1;
        chk("rst_gnt",       32'(gnt),       32'h0);
        chk("rst_bank_req",  32'(bank_req),  32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_r_valid",   32'(r_valid),   32'h0);

        // Zero-fill: 16 writes of 0 to addresses 0..15, requests stall
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_req",   32'(bank_req),   32'h1);
            chk("init_we",    32'(bank_we),    32'h1);
            chk("init_addr",  32'(bank_addr),  32'(i));
            chk("init_wdata", 32'(bank_wdata), 32'h0);
            chk("init_be",    32'(bank_be),    32'hF);
            chk("init_gnt",   32'(gnt),        32'h0);
            chk("init_done_low", 32'(init_done), 32'h0);
            @(negedge clk);
        end
        req = '0; #1;
        chk("init_done_rise", 32'(init_done), 32'h1);
        chk("idle_gnt",       32'(gnt),       32'h0);
        chk("idle_bank_req",  32'(bank_req),  32'h0);

        // Requester 2 writes 0xDEADBEEF to address 5, then reads it back
        @(negedge clk);
        req = 4'b0100; wen[2] = 1'b0; add[2] = 4'd5; wdata[2] = 32'hDEAD_BEEF; #1;
        chk("wr_gnt",   32'(gnt),        32'h4);
        chk("wr_we",    32'(bank_we),    32'h1);
        chk("wr_addr",  32'(bank_addr),  32'h5);
        chk("wr_wdata", 32'(bank_wdata), 32'hDEAD_BEEF);
        @(negedge clk);
        wen[2] = 1'b1; #1;
        chk("wr_ack",   32'(r_valid), 32'h4);
        chk("rd_gnt",   32'(gnt),     32'h4);
        chk("rd_we",    32'(bank_we), 32'h0);
        @(negedge clk);
        idle_inputs(); #1;
        chk("rd_valid", 32'(r_valid), 32'h4);
        chk("rd_data",  r_rdata,      32'hDEAD_BEEF);

        // Requester 3 reads address 7 (zero-filled); pointer returns to 0
        @(negedge clk);
        req = 4'b1000; add[3] = 4'd7; #1;
        chk("r3_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        idle_inputs(); #1;
        chk("r3_valid", 32'(r_valid), 32'h8);
        chk("zero_fill_data", r_rdata, 32'h0);

        // All four requesting for 8 cycles: grant 0,1,2,3,0,1,2,3
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req = 4'b1111;
            for (int k = 0; k < NB; k++) add[k] = AW'(k);
            #1;
            chk("rr_gnt", 32'(gnt), 32'(1) << (c % 4));
            if (c > 0) chk("rr_valid", 32'(r_valid), 32'(1) << ((c - 1) % 4));
        end
        @(negedge clk);
        idle_inputs(); #1;
        chk("rr_last_valid", 32'(r_valid), 32'h8);
        chk("rr_idle_gnt",   32'(gnt),     32'h0);

        // Move pointer to 2, then requests 1 and 3: grant 3, then 1, pointer ends at 2
        @(negedge clk); req = 4'b0010; #1;
        chk("ptr2_gnt", 32'(gnt), 32'h2);
        @(negedge clk); req = 4'b1010; #1;
        chk("sparse_gnt_a", 32'(gnt), 32'h8);
        chk("sparse_valid_a", 32'(r_valid), 32'h2);
        @(negedge clk); req = 4'b1010; #1;
        chk("sparse_gnt_b", 32'(gnt), 32'h2);
        chk("sparse_valid_b", 32'(r_valid), 32'h8);
        @(negedge clk); req = 4'b1111; #1;
        chk("ptr_after_sparse", 32'(gnt), 32'h4);
        @(negedge clk); idle_inputs(); #1;
        chk("ptr_after_valid", 32'(r_valid), 32'h4);

        // Byte enables: write all-ones with be=0101 over zero, read 0x00FF00FF
        @(negedge clk);
        req = 4'b0001; wen[0] = 1'b0; add[0] = 4'd9; wdata[0] = 32'hFFFF_FFFF; be[0] = 4'b0101; #1;
        chk("be_gnt", 32'(gnt),     32'h1);
        chk("be_be",  32'(bank_be), 32'h5);
        @(negedge clk);
        wen[0] = 1'b1; be[0] = 4'b1111; #1;
        chk("be_rd_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        idle_inputs(); #1;
        chk("be_valid", 32'(r_valid), 32'h1);
        chk("be_data",  r_rdata,      32'h00FF_00FF);

        // Reset while a read response is pending: response dropped, zero-fill restarts
        @(negedge clk);
        req = 4'b0010; add[1] = 4'd5; #1;
        chk("pend_gnt", 32'(gnt), 32'h2);
        rst = 1'b1; #1;
        chk("pend_gnt_gated", 32'(gnt), 32'h0);
        @(negedge clk); idle_inputs(); #1;
        chk("pend_dropped",   32'(r_valid),   32'h0);
        chk("pend_init_done", 32'(init_done), 32'h0);
        chk("pend_bank_req",  32'(bank_req),  32'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk("reinit_addr0", 32'(bank_addr), 32'h0);
        chk("reinit_req",   32'(bank_req),  32'h1);
        for (int i = 0; i < 5; i++) @(negedge clk);
        #1;
        chk("reinit_addr5", 32'(bank_addr), 32'h5);

        // Reset in the middle of INIT restarts from address 0
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("midinit_addr0", 32'(bank_addr), 32'h0);
        for (int i = 0; i < 16; i++) @(negedge clk);
        #1;
        chk("reinit_done", 32'(init_done), 32'h1);

        // Pointer is back at 0; address 5 was zero-filled again
        req = 4'b1111; add[0] = 4'd5; #1;
        chk("reset_ptr_gnt", 32'(gnt), 32'h1);
        @(negedge clk); idle_inputs(); #1;
        chk("refill_valid", 32'(r_valid), 32'h1);
        chk("refill_data",  r_rdata,      32'h0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
